// File: rtl/bus_control_unit.sv
// Bus control unit: owns the external 16-bit bus and arbitrates between
// EU data/IO accesses and instruction prefetch. It sequences each bus
// cycle (status, byte lanes, odd-word splitting, readyb wait states) and
// returns fetched data to the prefetch queue or to the EU.
module bus_control_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic        readyb,
   input  logic [15:0] data_in,
   input  logic [2:0]  eu_command,
   input  logic [19:0] eu_address,
   input  logic        eu_word,
   input  logic [15:0] eu_wdata,
   output logic        eu_done,
   output logic [15:0] eu_rdata,
   input  logic [19:0] pf_address,
   input  logic        queue_full,
   input  logic        queue_suspend,
   input  logic        queue_flush,
   output logic        pf_push,
   output logic        pf_push_two,
   output logic [15:0] pf_data,
   output logic [19:0] address_out,
   output logic [3:0]  bus_status,
   output logic        bus_ube,
   output logic [15:0] data_out
);

   typedef enum logic [1:0] {ST_IDLE, ST_PF, ST_EU1, ST_EU2} state_t;

   localparam logic [3:0] STAT_IDLE = 4'hF;
   localparam logic [3:0] STAT_MRD  = 4'h9;

   state_t      state_q, state_d;
   logic [19:0] address_out_q, address_out_d;
   logic [3:0]  bus_status_q, bus_status_d;
   logic        bus_ube_q, bus_ube_d;
   logic [15:0] data_out_q, data_out_d;
   logic        eu_done_q, eu_done_d;
   logic [15:0] eu_rdata_q, eu_rdata_d;
   logic        pf_push_q, pf_push_d;
   logic        pf_push_two_q, pf_push_two_d;
   logic [15:0] pf_data_q, pf_data_d;
   logic        discard_q, discard_d;
   logic [7:0]  lo_byte_q, lo_byte_d;

   logic        eu_req;
   logic        eu_read;
   logic [3:0]  eu_status;
   logic        eu_split;
   logic [15:0] eu_lane_data;

   // Decode the EU command; codes outside 1..4 are not treated as requests
   // so an undefined command never starts a bus cycle with an idle status.
   always_comb begin
      eu_req    = 1'b1;
      eu_read   = 1'b0;
      eu_status = STAT_IDLE;
      case (eu_command)
         3'd1: begin eu_status = 4'h9; eu_read = 1'b1; end
         3'd2: eu_status = 4'hA;
         3'd3: begin eu_status = 4'h5; eu_read = 1'b1; end
         3'd4: eu_status = 4'h6;
         default: eu_req = 1'b0;
      endcase
   end

   assign eu_split = eu_word & eu_address[0];

   // Steer write data for the first (or only) EU cycle onto its byte lane.
   always_comb begin
      eu_lane_data = 16'h0000;
      if (!eu_read) begin
         if (eu_address[0])
            eu_lane_data = {eu_wdata[7:0], 8'h00};
         else if (eu_word)
            eu_lane_data = eu_wdata;
         else
            eu_lane_data = {8'h00, eu_wdata[7:0]};
      end
   end

   // Next-state and registered-output logic for the bus cycle sequencer.
   always_comb begin
      state_d       = state_q;
      address_out_d = address_out_q;
      bus_status_d  = bus_status_q;
      bus_ube_d     = bus_ube_q;
      data_out_d    = data_out_q;
      eu_done_d     = 1'b0;
      eu_rdata_d    = eu_rdata_q;
      pf_push_d     = 1'b0;
      pf_push_two_d = pf_push_two_q;
      pf_data_d     = pf_data_q;
      discard_d     = discard_q;
      lo_byte_d     = lo_byte_q;

      case (state_q)
         ST_IDLE: begin
            discard_d = 1'b0;
            if (eu_req) begin
               state_d       = ST_EU1;
               address_out_d = eu_address;
               bus_status_d  = eu_status;
               bus_ube_d     = eu_word | eu_address[0];
               data_out_d    = eu_lane_data;
            end else if (!queue_full && !queue_suspend && !queue_flush) begin
               state_d       = ST_PF;
               address_out_d = pf_address;
               bus_status_d  = STAT_MRD;
               bus_ube_d     = 1'b1;
               data_out_d    = 16'h0000;
            end
         end

         ST_PF: begin
            discard_d = discard_q | queue_flush;
            if (!readyb) begin
               state_d      = ST_IDLE;
               bus_status_d = STAT_IDLE;
               discard_d    = 1'b0;
               if (!(discard_q | queue_flush)) begin
                  pf_push_d     = 1'b1;
                  // An odd fetch address yields only the upper-lane byte.
                  pf_push_two_d = ~address_out_q[0];
                  pf_data_d     = address_out_q[0] ? {8'h00, data_in[15:8]} : data_in;
               end
            end
         end

         ST_EU1: begin
            if (!readyb) begin
               if (eu_split) begin
                  // Low byte came on the upper lane; fetch the high byte next.
                  state_d       = ST_EU2;
                  address_out_d = address_out_q + 20'd1;
                  bus_ube_d     = 1'b0;
                  data_out_d    = eu_read ? 16'h0000 : {8'h00, eu_wdata[15:8]};
                  lo_byte_d     = data_in[15:8];
               end else begin
                  state_d      = ST_IDLE;
                  bus_status_d = STAT_IDLE;
                  eu_done_d    = 1'b1;
                  if (eu_read) begin
                     if (address_out_q[0])
                        eu_rdata_d = {8'h00, data_in[15:8]};
                     else if (eu_word)
                        eu_rdata_d = data_in;
                     else
                        eu_rdata_d = {8'h00, data_in[7:0]};
                  end
               end
            end
         end

         ST_EU2: begin
            if (!readyb) begin
               state_d      = ST_IDLE;
               bus_status_d = STAT_IDLE;
               eu_done_d    = 1'b1;
               if (eu_read)
                  eu_rdata_d = {data_in[7:0], lo_byte_q};
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   // State and output registers; reset aborts any cycle in flight.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         address_out_q <= 20'hFFFFF;
         bus_status_q  <= STAT_IDLE;
         bus_ube_q     <= 1'b0;
         data_out_q    <= 16'h0000;
         eu_done_q     <= 1'b0;
         eu_rdata_q    <= 16'h0000;
         pf_push_q     <= 1'b0;
         pf_push_two_q <= 1'b0;
         pf_data_q     <= 16'h0000;
         discard_q     <= 1'b0;
         lo_byte_q     <= 8'h00;
      end else begin
         state_q       <= state_d;
         address_out_q <= address_out_d;
         bus_status_q  <= bus_status_d;
         bus_ube_q     <= bus_ube_d;
         data_out_q    <= data_out_d;
         eu_done_q     <= eu_done_d;
         eu_rdata_q    <= eu_rdata_d;
         pf_push_q     <= pf_push_d;
         pf_push_two_q <= pf_push_two_d;
         pf_data_q     <= pf_data_d;
         discard_q     <= discard_d;
         lo_byte_q     <= lo_byte_d;
      end
   end

   assign address_out = address_out_q;
   assign bus_status  = bus_status_q;
   assign bus_ube     = bus_ube_q;
   assign data_out    = data_out_q;
   assign eu_done     = eu_done_q;
   assign eu_rdata    = eu_rdata_q;
   assign pf_push     = pf_push_q;
   assign pf_push_two = pf_push_two_q;
   assign pf_data     = pf_data_q;

endmodule

// File: tb/tb_bus_control_unit.sv
// Directed testbench for bus_control_unit: each task drives one scenario
// and compares registered outputs against hand-computed values.
module tb_bus_control_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        readyb;
   logic [15:0] data_in;
   logic [2:0]  eu_command;
   logic [19:0] eu_address;
   logic        eu_word;
   logic [15:0] eu_wdata;
   logic        eu_done;
   logic [15:0] eu_rdata;
   logic [19:0] pf_address;
   logic        queue_full;
   logic        queue_suspend;
   logic        queue_flush;
   logic        pf_push;
   logic        pf_push_two;
   logic [15:0] pf_data;
   logic [19:0] address_out;
   logic [3:0]  bus_status;
   logic        bus_ube;
   logic [15:0] data_out;

   int checks = 0;
   int errors = 0;

   bus_control_unit dut (
      .clk           (clk),
      .reset         (reset),
      .readyb        (readyb),
      .data_in       (data_in),
      .eu_command    (eu_command),
      .eu_address    (eu_address),
      .eu_word       (eu_word),
      .eu_wdata      (eu_wdata),
      .eu_done       (eu_done),
      .eu_rdata      (eu_rdata),
      .pf_address    (pf_address),
      .queue_full    (queue_full),
      .queue_suspend (queue_suspend),
      .queue_flush   (queue_flush),
      .pf_push       (pf_push),
      .pf_push_two   (pf_push_two),
      .pf_data       (pf_data),
      .address_out   (address_out),
      .bus_status    (bus_status),
      .bus_ube       (bus_ube),
      .data_out      (data_out)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 ns past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; readyb = 1'b1; data_in = 16'h0; eu_command = 3'd0;
      eu_address = 20'h0; eu_word = 1'b0; eu_wdata = 16'h0;
      pf_address = 20'h0; queue_full = 1'b1; queue_suspend = 1'b0; queue_flush = 1'b0;
      tick(); tick();
      reset = 1'b0;
      checks++; if (address_out !== 20'hFFFFF) begin errors++; $display("FAIL reset_addr: got %h expected fffff", address_out); end
      checks++; if (bus_status !== 4'hF) begin errors++; $display("FAIL reset_status: got %h expected f", bus_status); end
      checks++; if ({bus_ube, data_out, eu_done, eu_rdata, pf_push, pf_push_two, pf_data} !== 52'h0) begin
         errors++; $display("FAIL reset_outputs: ube=%b dout=%h done=%b rdata=%h push=%b two=%b pdata=%h expected all zero",
                            bus_ube, data_out, eu_done, eu_rdata, pf_push, pf_push_two, pf_data); end
      // Start a prefetch, then reset it while waiting on readyb.
      queue_full = 1'b0; pf_address = 20'hF0000; data_in = 16'h1111;
      tick();
      checks++; if (bus_status !== 4'h9) begin errors++; $display("FAIL reset_pf_grant: got %h expected 9", bus_status); end
      queue_full = 1'b1; reset = 1'b1;
      tick();
      reset = 1'b0;
      checks++; if (address_out !== 20'hFFFFF || bus_status !== 4'hF) begin
         errors++; $display("FAIL reset_mid_pf: addr=%h status=%h expected fffff f", address_out, bus_status); end
      readyb = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++; if (pf_push !== 1'b0) begin errors++; $display("FAIL reset_no_push: got %b expected 0 (clk %0d)", pf_push, i); end
      end
      $display("txn reset mid-prefetch done");
   endtask

   task automatic test_prefetch();
      readyb = 1'b0; queue_full = 1'b0; pf_address = 20'hF0000; data_in = 16'hBBAA;
      tick();
      checks++; if (bus_status !== 4'h9 || bus_ube !== 1'b1 || address_out !== 20'hF0000) begin
         errors++; $display("FAIL pf_even_grant: status=%h ube=%b addr=%h expected 9 1 f0000", bus_status, bus_ube, address_out); end
      queue_full = 1'b1;
      tick();
      checks++; if (pf_push !== 1'b1 || pf_push_two !== 1'b1 || pf_data !== 16'hBBAA) begin
         errors++; $display("FAIL pf_even_push: push=%b two=%b data=%h expected 1 1 bbaa", pf_push, pf_push_two, pf_data); end
      checks++; if (bus_status !== 4'hF) begin errors++; $display("FAIL pf_even_idle: got %h expected f", bus_status); end
      tick();
      checks++; if (pf_push !== 1'b0) begin errors++; $display("FAIL pf_push_pulse: got %b expected 0", pf_push); end
      $display("txn prefetch even addr=f0000 data=bbaa");
      queue_full = 1'b0; pf_address = 20'hF0001;
      tick();
      checks++; if (address_out !== 20'hF0001 || bus_ube !== 1'b1) begin
         errors++; $display("FAIL pf_odd_grant: addr=%h ube=%b expected f0001 1", address_out, bus_ube); end
      queue_full = 1'b1;
      tick();
      checks++; if (pf_push !== 1'b1 || pf_push_two !== 1'b0 || pf_data[7:0] !== 8'hBB) begin
         errors++; $display("FAIL pf_odd_push: push=%b two=%b data=%h expected 1 0 bb", pf_push, pf_push_two, pf_data[7:0]); end
      tick();
      $display("txn prefetch odd addr=f0001 byte=bb");
   endtask

   task automatic test_odd_write();
      readyb = 1'b0; eu_command = 3'd2; eu_address = 20'h12345; eu_wdata = 16'hBEEF; eu_word = 1'b1;
      tick();
      checks++; if (address_out !== 20'h12345 || bus_ube !== 1'b1 || data_out !== 16'hEF00 || bus_status !== 4'hA) begin
         errors++; $display("FAIL odd_wr_c1: addr=%h ube=%b dout=%h status=%h expected 12345 1 ef00 a",
                            address_out, bus_ube, data_out, bus_status); end
      tick();
      checks++; if (address_out !== 20'h12346 || bus_ube !== 1'b0 || data_out !== 16'h00BE || eu_done !== 1'b0) begin
         errors++; $display("FAIL odd_wr_c2: addr=%h ube=%b dout=%h done=%b expected 12346 0 00be 0",
                            address_out, bus_ube, data_out, eu_done); end
      tick();
      checks++; if (eu_done !== 1'b1 || bus_status !== 4'hF) begin
         errors++; $display("FAIL odd_wr_done: done=%b status=%h expected 1 f", eu_done, bus_status); end
      eu_command = 3'd0;
      tick();
      checks++; if (eu_done !== 1'b0 || bus_status !== 4'hF) begin
         errors++; $display("FAIL odd_wr_after: done=%b status=%h expected 0 f", eu_done, bus_status); end
      $display("txn mem write word addr=12345 data=beef");
   endtask

   task automatic test_wrap();
      readyb = 1'b0; eu_command = 3'd1; eu_address = 20'hFFFFF; eu_word = 1'b1; data_in = 16'h3400;
      tick();
      checks++; if (address_out !== 20'hFFFFF || bus_status !== 4'h9 || bus_ube !== 1'b1) begin
         errors++; $display("FAIL wrap_c1: addr=%h status=%h ube=%b expected fffff 9 1", address_out, bus_status, bus_ube); end
      tick();
      checks++; if (address_out !== 20'h00000 || bus_ube !== 1'b0) begin
         errors++; $display("FAIL wrap_c2: addr=%h ube=%b expected 00000 0", address_out, bus_ube); end
      data_in = 16'h0012;
      tick();
      checks++; if (eu_done !== 1'b1 || eu_rdata !== 16'h1234) begin
         errors++; $display("FAIL wrap_rdata: done=%b rdata=%h expected 1 1234", eu_done, eu_rdata); end
      eu_command = 3'd0;
      tick();
      $display("txn mem read word addr=fffff data=1234");
   endtask

   task automatic test_eu_aligned();
      // Even byte IO write with one wait state.
      readyb = 1'b1; eu_command = 3'd4; eu_address = 20'h00100; eu_word = 1'b0; eu_wdata = 16'h12AB;
      tick();
      checks++; if (bus_status !== 4'h6 || bus_ube !== 1'b0 || data_out !== 16'h00AB) begin
         errors++; $display("FAIL io_wr_grant: status=%h ube=%b dout=%h expected 6 0 00ab", bus_status, bus_ube, data_out); end
      tick();
      checks++; if (eu_done !== 1'b0 || bus_status !== 4'h6) begin
         errors++; $display("FAIL io_wr_wait: done=%b status=%h expected 0 6", eu_done, bus_status); end
      readyb = 1'b0;
      tick();
      checks++; if (eu_done !== 1'b1) begin errors++; $display("FAIL io_wr_done: got %b expected 1", eu_done); end
      eu_command = 3'd0;
      tick();
      $display("txn io write byte addr=00100 data=ab");
      // Even word memory read in a single cycle.
      eu_command = 3'd1; eu_address = 20'h00200; eu_word = 1'b1; data_in = 16'hCAFE;
      tick();
      checks++; if (bus_ube !== 1'b1 || address_out !== 20'h00200) begin
         errors++; $display("FAIL rd_word_grant: ube=%b addr=%h expected 1 00200", bus_ube, address_out); end
      tick();
      checks++; if (eu_done !== 1'b1 || eu_rdata !== 16'hCAFE) begin
         errors++; $display("FAIL rd_word_data: done=%b rdata=%h expected 1 cafe", eu_done, eu_rdata); end
      eu_command = 3'd0;
      tick();
      $display("txn mem read word addr=00200 data=cafe");
   endtask

   task automatic test_arb_flush();
      readyb = 1'b1; queue_full = 1'b0; pf_address = 20'hF0010; data_in = 16'h5566;
      tick();
      checks++; if (bus_status !== 4'h9) begin errors++; $display("FAIL arb_pf_grant: got %h expected 9", bus_status); end
      queue_full = 1'b1; eu_command = 3'd3; eu_address = 20'h00041; eu_word = 1'b0;
      tick();
      checks++; if (bus_status !== 4'h9 || address_out !== 20'hF0010) begin
         errors++; $display("FAIL arb_no_preempt: status=%h addr=%h expected 9 f0010", bus_status, address_out); end
      queue_flush = 1'b1;
      tick();
      queue_flush = 1'b0; readyb = 1'b0;
      tick();
      checks++; if (pf_push !== 1'b0 || bus_status !== 4'hF) begin
         errors++; $display("FAIL arb_flush_discard: push=%b status=%h expected 0 f", pf_push, bus_status); end
      data_in = 16'h7700;
      tick();
      checks++; if (bus_status !== 4'h5 || address_out !== 20'h00041 || bus_ube !== 1'b1 || pf_push !== 1'b0) begin
         errors++; $display("FAIL arb_io_grant: status=%h addr=%h ube=%b push=%b expected 5 00041 1 0",
                            bus_status, address_out, bus_ube, pf_push); end
      tick();
      checks++; if (eu_done !== 1'b1 || eu_rdata !== 16'h0077) begin
         errors++; $display("FAIL arb_io_rdata: done=%b rdata=%h expected 1 0077", eu_done, eu_rdata); end
      eu_command = 3'd0;
      tick();
      $display("txn prefetch flushed, io read addr=00041 data=77");
   endtask

   task automatic test_suspend();
      readyb = 1'b0; eu_command = 3'd0; queue_full = 1'b0; queue_suspend = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++; if (bus_status !== 4'hF) begin errors++; $display("FAIL suspend_idle: got %h expected f (clk %0d)", bus_status, i); end
      end
      queue_suspend = 1'b0; queue_full = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++; if (bus_status !== 4'hF) begin errors++; $display("FAIL full_idle: got %h expected f (clk %0d)", bus_status, i); end
      end
      $display("txn suspend/full hold idle");
   endtask

   initial begin
      test_reset();
      test_prefetch();
      test_odd_write();
      test_wrap();
      test_eu_aligned();
      test_arb_flush();
      test_suspend();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
